// File: rtl/out_port_arbiter.sv
// Per-output-port arbiter: round-robin pick among five inputs, grant locked
// from HEADER to TAIL, with a downstream credit counter gating each flit.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module out_port_arbiter #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [4:0]    empty,
    input  logic [14:0]   flit_id_in,
    input  logic          credit_in,
    output logic [4:0]    grant,
    output logic [2:0]    xbar_sel,
    output logic [4:0]    rd_en,
    output logic          valid_out,
    output logic [CW-1:0] credit_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        r_state, w_state_nxt;
    logic [4:0]    r_grant, w_grant_nxt;
    logic [2:0]    r_sel, w_sel_nxt;
    logic [2:0]    r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_credit, w_credit_nxt;

    logic          w_found;
    logic [2:0]    w_win;
    logic [3:0]    w_idx;
    logic          w_empty_g;
    logic [2:0]    w_fid_g;
    logic          w_valid;
    logic          w_tail;

    // Cyclic search starting just after the last packet's owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'd5)
                w_idx = w_idx - 4'd5;
            if (!w_found && req[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_empty_g = 1'b1;
        w_fid_g   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (r_sel == 3'(i)) begin
                w_empty_g = empty[i];
                w_fid_g   = flit_id_in[3*i +: 3];
            end
        end
    end

    assign w_valid = (r_state == LOCKED) && !w_empty_g
                     && (r_credit != '0);
    assign w_tail  = w_valid && (w_fid_g == `TAIL);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = 5'b00001 << w_win;
                    w_sel_nxt   = w_win;
                end
            end
            LOCKED: begin
                if (w_tail) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 5'b00000;
                    w_sel_nxt   = 3'd0;
                    w_ptr_nxt   = r_sel;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A returned credit with a full counter is dropped, not wrapped.
    always_comb begin
        w_credit_nxt = r_credit;
        if (w_valid && !credit_in)
            w_credit_nxt = r_credit - CW'(1);
        else if (!w_valid && credit_in && r_credit != CW'(CREDITS))
            w_credit_nxt = r_credit + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= 5'b00000;
            r_sel    <= 3'd0;
            r_ptr    <= 3'd4;
            r_credit <= CW'(CREDITS);
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_sel    <= w_sel_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    assign grant      = r_grant;
    assign xbar_sel   = r_sel;
    assign valid_out  = w_valid;
    assign rd_en      = w_valid ? r_grant : 5'b00000;
    assign credit_cnt = r_credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(credit_in && r_credit == CW'(CREDITS)))
                else $warning("credit returned with counter already full");
            assert ($onehot0(r_grant))
                else $error("grant not one-hot");
            assert ((rd_en & ~r_grant) == 5'b00000)
                else $error("rd_en outside grant");
        end
    end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Scoreboard bench for out_port_arbiter: a FIFO model feeds the five inputs,
// a negedge monitor checks every forwarded flit against the expected queue.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module tb_out_port_arbiter;

    typedef struct {
        int         src;
        logic [2:0] fid;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  req = 5'b0;
    logic [4:0]  empty = 5'h1f;
    logic [14:0] flit_id_in = 15'b0;
    logic        credit_in;
    logic [4:0]  grant;
    logic [2:0]  xbar_sel;
    logic [4:0]  rd_en;
    logic        valid_out;
    logic [2:0]  credit_cnt;

    logic        auto_en = 1'b0;
    logic        auto_pulse = 1'b0;
    logic        man_credit = 1'b0;

    ent_t fifo_q[$];
    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    out_port_arbiter #(.CREDITS(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .empty      (empty),
        .flit_id_in (flit_id_in),
        .credit_in  (credit_in),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .rd_en      (rd_en),
        .valid_out  (valid_out),
        .credit_cnt (credit_cnt)
    );

    always #5 clk = ~clk;

    // Downstream returns one credit the cycle after each accepted flit.
    always @(posedge clk) auto_pulse <= valid_out;
    assign credit_in = auto_en ? auto_pulse : man_credit;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, expv);
        end
    endtask

    task automatic refresh();
        empty      = 5'h1f;
        flit_id_in = 15'b0;
        for (int k = fifo_q.size() - 1; k >= 0; k--) begin
            empty[fifo_q[k].src] = 1'b0;
            flit_id_in[fifo_q[k].src*3 +: 3] = fifo_q[k].fid;
        end
    endtask

    task automatic pop_src(input int s);
        for (int k = 0; k < fifo_q.size(); k++) begin
            if (fifo_q[k].src == s) begin
                fifo_q.delete(k);
                break;
            end
        end
    endtask

    task automatic load(input int s, input logic [2:0] f);
        ent_t e;
        e.src = s;
        e.fid = f;
        fifo_q.push_back(e);
        exp_q.push_back(e);
        refresh();
    endtask

    task automatic cyc();
        logic [4:0] r;
        @(posedge clk);
        r = rd_en;
        #1;
        for (int i = 0; i < 5; i++)
            if (r[i]) pop_src(i);
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 5'b0;
        man_credit = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        refresh();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            cyc();
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        ent_t        e;
        logic [15:0] a, x;
        if (rst && valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer sel=%0d", xbar_sel);
            end else begin
                e = exp_q.pop_front();
                a = {grant, xbar_sel, rd_en, flit_id_in[xbar_sel*3 +: 3]};
                x = {5'(1 << e.src), 3'(e.src), 5'(1 << e.src), e.fid};
                if (a !== x) begin
                    errors++;
                    $display("FAIL xfer got=%h exp=%h", a, x);
                end
            end
        end
    end

    initial begin
        // Reset state, with requests present.
        req = 5'h1f;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_sel", xbar_sel, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_rden", rd_en, 0);
        chk("rst_credit", credit_cnt, 4);

        // Single 3-flit packet from E.
        do_reset();
        auto_en = 1'b1;
        load(1, `HEADER);
        load(1, `PAYLOAD);
        load(1, `TAIL);
        req = 5'b00010;
        cyc();
        req = 5'b0;
        @(negedge clk);
        chk("t1_grant", grant, 5'b00010);
        chk("t1_sel", xbar_sel, 1);
        chk("t1_rden", rd_en, 5'b00010);
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge clk);
            chk("t1_valid", valid_out, 1);
        end
        cyc();
        @(negedge clk);
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_sel", xbar_sel, 0);
        chk("t1_idle_valid", valid_out, 0);

        // Pointer now at E: with E and W requesting, W wins.
        load(2, `TAIL);
        load(1, `TAIL);
        req = 5'b00110;
        cyc();
        req = 5'b00010;
        @(negedge clk);
        chk("ptr_grant_w", grant, 5'b00100);
        wait_drain("ptr_drain");
        req = 5'b0;

        // Round robin with all inputs requesting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load(i, `HEADER);
            load(i, `TAIL);
        end
        load(0, `HEADER);
        load(0, `TAIL);
        req = 5'h1f;
        cyc();
        @(negedge clk);
        chk("rr_first_n", grant, 5'b00001);
        wait_drain("rr_drain");
        req = 5'b0;

        // Grant held through request changes mid-packet.
        do_reset();
        load(0, `HEADER);
        load(0, `PAYLOAD);
        load(0, `TAIL);
        load(3, `HEADER);
        load(3, `TAIL);
        req = 5'b00001;
        cyc();
        req = 5'b01000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lock_grant_n", grant, 5'b00001);
            cyc();
        end
        @(negedge clk);
        chk("lock_gap", grant, 0);
        cyc();
        @(negedge clk);
        chk("lock_grant_s", grant, 5'b01000);
        wait_drain("lock_drain");
        req = 5'b0;

        // Credit stall on a 6-flit packet.
        do_reset();
        auto_en = 1'b0;
        load(0, `HEADER);
        for (int k = 0; k < 4; k++) load(0, `PAYLOAD);
        load(0, `TAIL);
        req = 5'b00001;
        cyc();
        req = 5'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cs_valid", valid_out, 1);
            chk("cs_credit", credit_cnt, 4 - k);
            cyc();
        end
        @(negedge clk);
        chk("cs_stall_valid", valid_out, 0);
        chk("cs_stall_credit", credit_cnt, 0);
        cyc();
        @(negedge clk);
        chk("cs_stall_valid2", valid_out, 0);
        man_credit = 1'b1;
        cyc();
        man_credit = 1'b0;
        @(negedge clk);
        chk("cs_fifth_valid", valid_out, 1);
        cyc();
        @(negedge clk);
        chk("cs_after_valid", valid_out, 0);
        chk("cs_after_credit", credit_cnt, 0);
        man_credit = 1'b1;
        cyc();
        man_credit = 1'b0;
        @(negedge clk);
        chk("cs_tail_valid", valid_out, 1);
        cyc();
        @(negedge clk);
        chk("cs_end_grant", grant, 0);
        chk("cs_end_credit", credit_cnt, 0);
        wait_drain("cs_drain");

        // Simultaneous use and return, then saturation.
        do_reset();
        load(0, `HEADER);
        load(0, `PAYLOAD);
        load(0, `PAYLOAD);
        load(0, `TAIL);
        req = 5'b00001;
        cyc();
        req = 5'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("sim_pre_credit", credit_cnt, 2);
        chk("sim_pre_valid", valid_out, 1);
        man_credit = 1'b1;
        cyc();
        man_credit = 1'b0;
        @(negedge clk);
        chk("sim_credit", credit_cnt, 2);
        cyc();
        man_credit = 1'b1;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("sat_full", credit_cnt, 4);
        cyc();
        man_credit = 1'b0;
        @(negedge clk);
        chk("sat_hold", credit_cnt, 4);
        wait_drain("sim_drain");

        // Async reset mid-packet, then fresh arbitration.
        do_reset();
        auto_en = 1'b1;
        load(0, `HEADER);
        load(0, `PAYLOAD);
        load(0, `PAYLOAD);
        load(0, `TAIL);
        req = 5'b00001;
        cyc();
        req = 5'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("ar_grant", grant, 0);
        chk("ar_valid", valid_out, 0);
        chk("ar_credit", credit_cnt, 4);
        fifo_q.delete();
        exp_q.delete();
        refresh();
        req = 5'h1f;
        load(0, `HEADER);
        load(0, `TAIL);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("ar_first_n", grant, 5'b00001);
        req = 5'b0;
        wait_drain("ar_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
- One instance per router output port (N/E/W/S/L). Sits directly downstream of the five per-input LBDR stages.
- Collects each LBDR's request for this output, picks one input with round-robin priority, and locks the grant for the whole packet (HEADER through TAIL).
- Drives crossbar select and the input-FIFO read strobe.
- Holds a credit counter for the downstream buffer. A flit is forwarded only when a downstream slot is free.

Parameters:
- CREDITS, 4, downstream buffer depth in flits. Also the reset value and saturation ceiling of the credit counter.
- CW, 3, credit counter width. Must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  5  per-input request for this output port from that input's LBDR. Bit order [0]=N, [1]=E, [2]=W, [3]=S, [4]=L.
- empty  in  5  per-input FIFO empty flags, same bit order.
- flit_id_in  in  15  per-input head-of-FIFO flit_id, 3 bits per input. Input i occupies [3i+2:3i]. Encoded with `HEADER/`PAYLOAD/`TAIL.
- credit_in  in  1  one-cycle pulse: downstream freed one slot.
- grant  out  5  one-hot registered grant, 0 when idle.
- xbar_sel  out  3  index 0..4 of the granted input, 0 when idle.
- rd_en  out  5  one-hot FIFO pop for the granted input, combinational.
- valid_out  out  1  flit transferred to the output link this cycle.
- credit_cnt  out  CW  current credits, for debug and coverage.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; grant=0; xbar_sel=0; credit_cnt=CREDITS.
  - Priority pointer ptr=4 (L), so N has highest priority first.
  - rd_en and valid_out are 0.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - If req!=0, search cyclically from (ptr+1) mod 5 upward and take the first set bit w.
  - At the next edge: grant=onehot(w), xbar_sel=w, state=LOCKED.
  - If req==0, stay in IDLE.
  - valid_out=0 throughout IDLE.
  - Latency: req seen in cycle t gives grant in cycle t+1.
- LOCKED:
  - req is ignored; the grant is held regardless of req changes.
  - valid_out = ~empty[g] & (credit_cnt!=0). rd_en = valid_out ? grant : 0. Both combinational, in the same cycle.
  - If valid_out=1 and flit_id_in[g]==`TAIL: at the next edge state=IDLE, grant=0, xbar_sel=0, ptr=g.
  - Re-arbitration therefore starts in the cycle after the TAIL leaves. Minimum gap between packets is 1 idle cycle.
  - If valid_out=0 (FIFO empty or no credit), stall: hold state and grant with no timeout.
- Credits:
  - Next value is credit_cnt − valid_out + credit_in.
  - valid_out and credit_in in the same cycle: unchanged.
  - credit_in at credit_cnt==CREDITS: saturate and hold CREDITS. This is a protocol error, flagged only by an assertion.
  - credit_cnt never underflows, because valid_out requires credit_cnt!=0.
- The grant is always one-hot or 0, and rd_en is always a subset of grant.
- A packet ends only on `TAIL. HEADER/PAYLOAD flits never release the grant.
- Reset mid-packet: the grant drops immediately (async) and credits return to CREDITS. Upstream flushes are the upstream's responsibility.

Test Plan:
- Reset and single packet: req=5'b00010 (E). Input E FIFO holds HEADER, PAYLOAD, TAIL, with credits available.
  - Cycle 1: grant=00010, xbar_sel=1. valid_out on 3 consecutive cycles, rd_en=00010.
  - Returns to IDLE with grant=0 and ptr=1.
- Round-robin fairness: req=5'b11111 held continuously, each input sends 2-flit packets.
  - Grant order is N,E,W,S,L,N. No input is granted twice before the others.
- Lock through req glitch: grant=N, then req drops to 0 and req[S] rises mid-packet.
  - Grant stays 00001 until the N TAIL transfers; S is granted 1 cycle later.
- Credit stall: CREDITS=4, no credit_in, 6-flit packet.
  - Exactly 4 valid_out, then credit_cnt=0 and valid_out=0.
  - One credit_in pulse: next cycle a 5th transfer, credit_cnt stays 0.
- Simultaneous valid_out and credit_in at credit_cnt=2: credit_cnt stays 2. credit_in at 4 stays 4.
- Async reset mid-packet (after the 2nd flit): grant=0, valid_out=0 and credit_cnt=4 immediately, without waiting for a clock edge. The first arbitration after release picks N when req=11111.
